// File: rtl/mef_controle_rega_if.sv
// rtl/mef_controle_rega_if.sv - sensor/command bundle between the irrigation environment and mef_controle_rega
interface mef_controle_rega_if;
    logic       tick;
    logic [1:0] nivel;
    logic       umidade_baixa;
    logic       adubo_req;
    logic       erro;
    logic       rec;
    logic [1:0] mef1;
    logic [1:0] limpeza;
    logic       VE;
    logic       critico;
    logic       falha;

    modport master (
        output tick, nivel, umidade_baixa, adubo_req, erro, rec,
        input  mef1, limpeza, VE, critico, falha
    );

    modport slave (
        input  tick, nivel, umidade_baixa, adubo_req, erro, rec,
        output mef1, limpeza, VE, critico, falha
    );
endinterface

// File: rtl/mef_controle_rega.sv
// rtl/mef_controle_rega.sv - irrigation phase sequencer (idle/fill/irrigate/clean/fault), fertilizer dosing under MEF_REGA_ADUBO_EN
module mef_controle_rega #(
    parameter int unsigned T_REGA  = 10,
    parameter int unsigned T_LIMPA = 4,
    parameter int unsigned T_ADUBO = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mef_controle_rega_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ENCHE, S_REGA, S_LIMPA, S_FALHA} state_t;

    localparam logic [7:0] T_REGA_C  = 8'(T_REGA);
    localparam logic [7:0] T_LIMPA_C = 8'(T_LIMPA);

    if (T_REGA < 1 || T_REGA > 255 || T_LIMPA < 1 || T_LIMPA > 255 ||
        T_ADUBO < 1 || T_ADUBO > T_LIMPA) begin : g_bad_params
        $error("mef_controle_rega: timing parameters out of range");
    end

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       erro_q, erro_d;
    logic [1:0] mef1_q, mef1_d;
    logic [1:0] limpeza_q, limpeza_d;
    logic       ve_q, ve_d;
    logic       critico_q, critico_d;
    logic       falha_q, falha_d;
    logic       dose_d;

    assign cnt_inc = cnt_q + 8'd1;

    // erro_q remembers erro from the previous REGA cycle; two in a row latch the fault
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        erro_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.nivel <= 2'b01)    state_d = S_ENCHE;
                else if (bus.umidade_baixa) state_d = S_REGA;
            end
            S_ENCHE: begin
                if (bus.nivel == 2'b11) state_d = S_IDLE;
            end
            S_REGA: begin
                erro_d = bus.erro;
                if (bus.tick) cnt_d = cnt_inc;
                if (bus.erro && erro_q)                   state_d = S_FALHA;
                else if (bus.nivel == 2'b00)              state_d = S_ENCHE;
                else if (bus.tick && cnt_inc == T_REGA_C) state_d = S_LIMPA;
            end
            S_LIMPA: begin
                if (bus.tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == T_LIMPA_C) state_d = S_IDLE;
                end
            end
            S_FALHA: begin
                if (bus.rec && !bus.erro) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d  = 8'd0;
            erro_d = 1'b0;
        end
    end

`ifdef MEF_REGA_ADUBO_EN
    localparam logic [7:0] T_ADUBO_C = 8'(T_ADUBO);

    logic pend_q, pend_d;
    logic entra_limpa;

    assign entra_limpa = (state_d == S_LIMPA) && (state_q != S_LIMPA);

    // a request arriving on the entry edge itself is served by this cleaning, not the next
    always_comb begin
        pend_d = pend_q | (bus.adubo_req && (state_q != S_FALHA));
        dose_d = limpeza_q[0];
        if (state_q == S_LIMPA && bus.tick && cnt_inc >= T_ADUBO_C) dose_d = 1'b0;
        if (entra_limpa) begin
            dose_d = pend_q | bus.adubo_req;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end
`else
    assign dose_d = 1'b0;
`endif

    always_comb begin
        case (state_d)
            S_ENCHE: mef1_d = 2'b01;
            S_LIMPA: mef1_d = 2'b10;
            S_REGA:  mef1_d = 2'b11;
            default: mef1_d = 2'b00;
        endcase
        limpeza_d = {state_d == S_LIMPA, (state_d == S_LIMPA) && dose_d};
        ve_d      = (state_d == S_ENCHE);
        falha_d   = (state_d == S_FALHA);
        critico_d = (bus.nivel != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            erro_q    <= 1'b0;
            mef1_q    <= 2'b00;
            limpeza_q <= 2'b00;
            ve_q      <= 1'b0;
            critico_q <= 1'b0;
            falha_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            erro_q    <= erro_d;
            mef1_q    <= mef1_d;
            limpeza_q <= limpeza_d;
            ve_q      <= ve_d;
            critico_q <= critico_d;
            falha_q   <= falha_d;
        end
    end

    assign bus.mef1    = mef1_q;
    assign bus.limpeza = limpeza_q;
    assign bus.VE      = ve_q;
    assign bus.critico = critico_q;
    assign bus.falha   = falha_q;
endmodule
